// File: rtl/mem_access_seq_pkg.sv
// Shared op/state encodings and lane helpers for the load/store sequencer.
// Pure declarations and combinational functions; no timing or flow control here.
package mem_access_seq_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic is_load(input op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_byte(input op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_aligned(input op_t op, input logic [1:0] addr_lo);
        if ((op == OP_LW) || (op == OP_SW)) return addr_lo == 2'b00;
        if (is_half(op))                    return !addr_lo[0];
        return 1'b1;
    endfunction

    // 8->32 and 16->32 extenders shared by every sub-word load path
    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sign_ext);
        return {{24{sign_ext & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sign_ext);
        return {{16{sign_ext & v[15]}}, v};
    endfunction

endpackage

// File: rtl/mem_access_seq_lane_extract.sv
// Picks the addressed byte/half lane out of a little-endian word and extends it.
// Purely combinational, zero latency, no flow control.
module mem_access_seq_lane_extract (
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    output logic [31:0] value
);
    import mem_access_seq_pkg::*;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? word[31:16] : word[15:0];
        case (op_t'(op))
            OP_LH:   value = ext16(half_lane, 1'b1);
            OP_LHU:  value = ext16(half_lane, 1'b0);
            OP_LB:   value = ext8(byte_lane, 1'b1);
            OP_LBU:  value = ext8(byte_lane, 1'b0);
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// One-at-a-time load/store sequencer with read-modify-write for SB/SH.
// Latency loads READ_WAIT+1, SW 2, SH/SB READ_WAIT+2, misaligned 1; req_ready only in IDLE.
module mem_access_seq #(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    import mem_access_seq_pkg::*;

    state_t      state;
    op_t         op_q;
    op_t         req_op_e;
    logic [1:0]  addr_lo;
    logic [15:0] wdata_lo;
    logic [2:0]  wait_cnt;
    logic [31:0] load_value;
    logic [31:0] merged;

    assign req_op_e   = op_t'(req_op);
    assign req_ready  = (state == ST_IDLE);
    assign mem_wr     = (state == ST_WR);
    assign resp_valid = (state == ST_RESP) || (state == ST_ERR);
    assign resp_err   = (state == ST_ERR);

    mem_access_seq_lane_extract u_lane_extract (
        .word  (mem_rdata),
        .addr  (addr_lo),
        .op    (op_q),
        .value (load_value)
    );

    // Sub-word store: overwrite only the addressed lane of the word just read
    always_comb begin
        merged = mem_rdata;
        if (is_byte(op_q)) merged[{addr_lo, 3'b000} +: 8] = wdata_lo[7:0];
        else               merged[{addr_lo[1], 4'b0000} +: 16] = wdata_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_LW;
            addr_lo    <= 2'b00;
            wdata_lo   <= 16'h0000;
            wait_cnt   <= 3'd0;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op_e;
                        addr_lo  <= req_addr[1:0];
                        wdata_lo <= req_wdata[15:0];
                        mem_addr <= {req_addr[31:2], 2'b00};
                        wait_cnt <= 3'(READ_WAIT - 1);
                        if (!is_aligned(req_op_e, req_addr[1:0])) begin
                            resp_rdata <= 32'h0;
                            state      <= ST_ERR;
                        end else if (req_op_e == OP_SW) begin
                            mem_wdata <= req_wdata;
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    // mem_rdata is only trusted on the last wait cycle
                    if (wait_cnt == 3'd0) begin
                        if (is_load(op_q)) begin
                            resp_rdata <= load_value;
                            state      <= ST_RESP;
                        end else begin
                            mem_wdata <= merged;
                            state     <= ST_WR;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_WR: begin
                    resp_rdata <= 32'h0;
                    state      <= ST_RESP;
                end
                ST_RESP, ST_ERR: state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
Multicycle controller that sequences every load/store the MIPS core issues against the word-wide data memory. It accepts one request at a time, waits out the memory read latency, and extracts and extends byte/halfword loads. Sub-word stores are done as read-modify-write. Misaligned accesses are reported as errors without touching memory. It sits between the control unit / ALU address path and the memory block, and replaces ad-hoc byte/half handling in the datapath.

Parameters:
READ_WAIT, 1, number of cycles from mem_addr valid to mem_rdata valid (legal range 1..7)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
req_addr  input  32  byte address
req_wdata  input  32  store data; the low 8/16 bits are used for SB/SH
resp_valid  output  1  one-cycle pulse: operation complete
resp_err  output  1  valid with resp_valid: misaligned access, no memory effect
resp_rdata  output  32  load result, held until the next response; 0 for stores and errors
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wr  output  1  memory write strobe
mem_wdata  output  32  word to write
mem_rdata  input  32  memory read data

Behaviour:
- States: IDLE, RD, WR, RESP, ERR.
- Reset (asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wr=0, mem_wdata=0. Reset mid-operation aborts the operation immediately. mem_wr drops in the same cycle, and no response is issued.
- IDLE: a request is accepted when req_valid and req_ready are both high. On acceptance the controller latches op, addr and wdata, and registers mem_addr.
- Alignment check at acceptance: LW/SW require addr[1:0]=00; LH/LHU/SH require addr[0]=0; bytes are always aligned.
- Misaligned request: go to ERR. ERR lasts 1 cycle with resp_valid=1, resp_err=1 and resp_rdata=0. mem_wr is never asserted. Then return to IDLE.
- Loads and SH/SB: go to RD and stay there exactly READ_WAIT cycles. mem_rdata is sampled only on the final RD edge.
  - Loads: extract, extend, register into resp_rdata, then go to RESP.
  - SH/SB: build the merged word into mem_wdata, then go to WR.
- SW: go straight to WR with mem_wdata=wdata.
- WR: 1 cycle with mem_wr=1. mem_wr is decoded from the state register and is high only in WR. Then go to RESP.
- RESP: 1 cycle with resp_valid=1 and resp_err=0, then IDLE. No request is accepted in RESP.
- Latency, counted in cycles after the acceptance cycle, to resp_valid:
  - loads: READ_WAIT+1
  - SW: 2
  - SH/SB: READ_WAIT+2
  - error: 1
- Back-to-back: the next acceptance is possible in the cycle after RESP/ERR.
- Lanes are little-endian. Byte lane k=addr[1:0] is bits [8k+7:8k]. Half lane h=addr[1] is bits [16h+15:16h].
- Load extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- Store merge: SB replaces byte lane k with wdata[7:0]. SH replaces half lane h with wdata[15:0]. All other bits keep the value read from memory.
- mem_addr holds the word address from acceptance until the next acceptance.
- req_op/req_addr/req_wdata are ignored outside the acceptance cycle.

Decomposition:
- Shared package: op encodings (OP_LW..OP_SB), state encoding, and helpers is_load/is_store/is_half/is_byte.
- One combinational sub-module, lane_extract (inputs: word, addr[1:0], op; output: 32-bit extended value). It reuses the existing 8->32 and 16->32 sign/zero-extend blocks.

Test Plan:
- Reset asserted -> all outputs at reset values, req_ready=1. Release reset, keep req_valid=0 for 10 cycles -> mem_wr stays 0 and resp_valid stays 0.
- Memory word 0x80FF1234 at 0x100, READ_WAIT=1:
  - LB 0x103 -> resp_valid at cycle 2, rdata 0xFFFFFF80.
  - LBU 0x103 -> 0x00000080.
  - LB 0x100 -> 0x00000034.
- Same word:
  - LH 0x102 -> 0xFFFF80FF.
  - LHU 0x102 -> 0x000080FF.
  - LW 0x100 -> 0x80FF1234.
  - LH 0x101 -> resp_err=1 at cycle 1, rdata 0, no mem_wr.
- Stores on word 0x11223344 at 0x200:
  - SB 0x201, wdata 0x000000AB -> mem_wr at cycle 2 with 0x1122AB44, resp at cycle 3.
  - SH 0x202, wdata 0xBEEF -> 0xBEEF3344.
  - SW 0x200, wdata 0xCAFEF00D -> mem_wr at cycle 1, resp at cycle 2.
- READ_WAIT=3, LBU 0x102 on 0x00A50000 -> mem_rdata sampled at cycle 3, resp at cycle 4 with 0x000000A5. Changing mem_rdata in cycles 1-2 has no effect.
- Reset pulse during RD of SB -> mem_wr never pulses, no resp_valid, req_ready=1 immediately. A following LW completes normally.
